// File: rtl/pia_bus_arbiter_pkg.sv
// Shared types and constants for the PIA register-bus arbiter.
package pia_bus_pkg;

    typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, BLOCKED} state_e;
    typedef enum logic {OWN_CPU, OWN_HOST} owner_e;

    localparam logic [6:0] ADR_INTIM  = 7'h04;
    localparam logic [6:0] ADR_INSTAT = 7'h05;

    // Reading these clears timer/interrupt flags inside the RIOT.
    function automatic logic is_side_effect_rd(input logic [6:0] adr);
        return (adr == ADR_INTIM) || (adr == ADR_INSTAT);
    endfunction

endpackage

// File: rtl/pia_bus_arbiter_starve_cnt.sv
// Saturating count of cycles the host has been kept waiting for the bus.
module pia_starve_cnt #(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic inc_i,
    input  logic clr_i,
    output logic at_max_o
);

    localparam logic [3:0] MaxW = 4'(MAX_WAIT);

    logic [3:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = 4'd0;
        end else if (inc_i && (cnt_q != MaxW)) begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_max_o = (cnt_q == MaxW);

endmodule

// File: rtl/pia_bus_arbiter.sv
// Arbitrates the single RIOT register bus between the 6502 and the host debug port.
module pia_bus_arbiter
    import pia_bus_pkg::*;
#(
    parameter int unsigned MAX_WAIT  = 15,
    parameter bit          HOST_SAFE = 1'b1
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       cpu_stb_i,
    input  logic       cpu_we_i,
    input  logic [6:0] cpu_adr_i,
    input  logic [7:0] cpu_dat_i,
    output logic       cpu_ack_o,
    output logic [7:0] cpu_dat_o,
    output logic       cpu_stall_o,
    input  logic       host_stb_i,
    input  logic       host_we_i,
    input  logic [6:0] host_adr_i,
    input  logic [7:0] host_dat_i,
    output logic       host_ack_o,
    output logic [7:0] host_dat_o,
    output logic       host_err_o,
    output logic       pia_stb_o,
    output logic       pia_we_o,
    output logic [6:0] pia_adr_o,
    output logic [7:0] pia_dat_o,
    input  logic [7:0] pia_dat_i
);

    state_e     state_q, state_d;
    owner_e     owner_q, owner_d;
    logic       we_q, we_d;
    logic [6:0] adr_q, adr_d;
    logic [7:0] wdat_q, wdat_d;
    logic [7:0] cpu_dat_q, cpu_dat_d;
    logic [7:0] host_dat_q, host_dat_d;
    logic       grant_cpu, grant_host;
    logic       host_at_max, cnt_inc, cnt_clr;
    logic       done;

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        we_d       = we_q;
        adr_d      = adr_q;
        wdat_d     = wdat_q;
        cpu_dat_d  = cpu_dat_q;
        host_dat_d = host_dat_q;
        grant_cpu  = 1'b0;
        grant_host = 1'b0;

        case (state_q)
            IDLE: begin
                // CPU has priority unless the host has waited out its budget.
                if (host_stb_i && (host_at_max || !cpu_stb_i)) begin
                    grant_host = 1'b1;
                    owner_d    = OWN_HOST;
                    if (HOST_SAFE && !host_we_i && is_side_effect_rd(host_adr_i)) begin
                        state_d = BLOCKED;
                    end else begin
                        state_d = ACCESS;
                        we_d    = host_we_i;
                        adr_d   = host_adr_i;
                        wdat_d  = host_dat_i;
                    end
                end else if (cpu_stb_i) begin
                    grant_cpu = 1'b1;
                    owner_d   = OWN_CPU;
                    state_d   = ACCESS;
                    we_d      = cpu_we_i;
                    adr_d     = cpu_adr_i;
                    wdat_d    = cpu_dat_i;
                end
            end
            ACCESS: state_d = we_q ? IDLE : CAPTURE;
            CAPTURE: begin
                state_d = IDLE;
                if (owner_q == OWN_CPU) begin
                    cpu_dat_d = pia_dat_i;
                end else begin
                    host_dat_d = pia_dat_i;
                end
            end
            BLOCKED: begin
                state_d    = IDLE;
                host_dat_d = 8'h00;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            owner_q    <= OWN_CPU;
            we_q       <= 1'b0;
            adr_q      <= 7'h00;
            wdat_q     <= 8'h00;
            cpu_dat_q  <= 8'h00;
            host_dat_q <= 8'h00;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            we_q       <= we_d;
            adr_q      <= adr_d;
            wdat_q     <= wdat_d;
            cpu_dat_q  <= cpu_dat_d;
            host_dat_q <= host_dat_d;
        end
    end

    assign cnt_inc = host_stb_i && !grant_host && !((state_q != IDLE) && (owner_q == OWN_HOST));
    assign cnt_clr = !host_stb_i || grant_host;

    pia_starve_cnt #(
        .MAX_WAIT(MAX_WAIT)
    ) u_starve_cnt (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .inc_i   (cnt_inc),
        .clr_i   (cnt_clr),
        .at_max_o(host_at_max)
    );

    // Acks are Moore outputs of the last busy cycle, so the following IDLE can re-grant.
    assign done        = ((state_q == ACCESS) && we_q) || (state_q == CAPTURE);
    assign cpu_ack_o   = done && (owner_q == OWN_CPU);
    assign host_ack_o  = (done && (owner_q == OWN_HOST)) || (state_q == BLOCKED);
    assign host_err_o  = (state_q == BLOCKED);
    assign cpu_dat_o   = ((state_q == CAPTURE) && (owner_q == OWN_CPU)) ? pia_dat_i : cpu_dat_q;
    assign host_dat_o  = (state_q == BLOCKED) ? 8'h00 :
                         ((state_q == CAPTURE) && (owner_q == OWN_HOST)) ? pia_dat_i : host_dat_q;
    assign cpu_stall_o = cpu_stb_i && !grant_cpu && !((state_q != IDLE) && (owner_q == OWN_CPU));

    assign pia_stb_o = (state_q == ACCESS);
    assign pia_we_o  = (state_q == ACCESS) && we_q;
    assign pia_adr_o = adr_q;
    assign pia_dat_o = wdat_q;

endmodule

// File: tb/tb_pia_bus_arbiter.sv
// Scoreboard bench for pia_bus_arbiter with a behavioural PIA and random traffic.
module tb_pia_bus_arbiter;

    localparam int unsigned MAX_WAIT  = 15;
    localparam bit          HOST_SAFE = 1'b1;

    logic       clk = 1'b0;
    logic       rst_ni = 1'b0;
    logic       cpu_stb_i = 1'b0, cpu_we_i = 1'b0;
    logic [6:0] cpu_adr_i = '0;
    logic [7:0] cpu_dat_i = '0;
    logic       cpu_ack_o, cpu_stall_o;
    logic [7:0] cpu_dat_o;
    logic       host_stb_i = 1'b0, host_we_i = 1'b0;
    logic [6:0] host_adr_i = '0;
    logic [7:0] host_dat_i = '0;
    logic       host_ack_o, host_err_o;
    logic [7:0] host_dat_o;
    logic       pia_stb_o, pia_we_o;
    logic [6:0] pia_adr_o;
    logic [7:0] pia_dat_o;
    logic [7:0] pia_dat_i = '0;

    always #5 clk = ~clk;

    pia_bus_arbiter #(
        .MAX_WAIT (MAX_WAIT),
        .HOST_SAFE(HOST_SAFE)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_ni),
        .cpu_stb_i  (cpu_stb_i),
        .cpu_we_i   (cpu_we_i),
        .cpu_adr_i  (cpu_adr_i),
        .cpu_dat_i  (cpu_dat_i),
        .cpu_ack_o  (cpu_ack_o),
        .cpu_dat_o  (cpu_dat_o),
        .cpu_stall_o(cpu_stall_o),
        .host_stb_i (host_stb_i),
        .host_we_i  (host_we_i),
        .host_adr_i (host_adr_i),
        .host_dat_i (host_dat_i),
        .host_ack_o (host_ack_o),
        .host_dat_o (host_dat_o),
        .host_err_o (host_err_o),
        .pia_stb_o  (pia_stb_o),
        .pia_we_o   (pia_we_o),
        .pia_adr_o  (pia_adr_o),
        .pia_dat_o  (pia_dat_o),
        .pia_dat_i  (pia_dat_i)
    );

    typedef struct {
        logic       we;
        logic [6:0] adr;
        logic [7:0] dat;
        logic       err;
    } txn_t;

    txn_t cpu_q[$];
    txn_t host_q[$];

    int n_tests = 0;
    int n_fail = 0;
    int strobe_cnt = 0;
    int exp_strobes = 0;
    int stall_cycles = 0;
    logic [7:0] cpu_hold = '0, host_hold = '0;
    logic       last_we = 1'b0, prev_stb = 1'b0;
    logic [6:0] last_adr = '0;
    logic [7:0] last_dat = '0;

    // Register contents the PIA model returns for a read of each address.
    function automatic logic [7:0] pia_val(input logic [6:0] a);
        return ~{1'b0, a};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // PIA: read data appears the cycle after the strobe; otherwise noise.
    initial begin
        logic       rd_seen;
        logic [6:0] rd_adr;
        forever begin
            @(negedge clk);
            rd_seen = pia_stb_o && !pia_we_o;
            rd_adr  = pia_adr_o;
            @(posedge clk);
            #1;
            pia_dat_i = rd_seen ? pia_val(rd_adr) : 8'($urandom);
        end
    end

    task automatic score(input string who, input txn_t t, input logic [7:0] dat_o,
                         input logic err_o, inout logic [7:0] hold);
        if (t.err) begin
            check({who, "_err_flag"}, err_o, 1);
            check({who, "_blocked_dat"}, dat_o, 8'h00);
            hold = 8'h00;
        end else begin
            check({who, "_err_flag"}, err_o, 0);
            exp_strobes++;
            check({who, "_bus_we"}, last_we, t.we);
            check({who, "_bus_adr"}, last_adr, t.adr);
            if (t.we) begin
                check({who, "_bus_wdat"}, last_dat, t.dat);
                check({who, "_dat_hold_on_write"}, dat_o, hold);
            end else begin
                check({who, "_rdata"}, dat_o, pia_val(t.adr));
                hold = pia_val(t.adr);
            end
        end
    endtask

    // Monitor: pops the expected transaction whenever a requester is acked.
    initial begin
        txn_t t;
        forever begin
            @(negedge clk);
            if (!rst_ni) begin
                cpu_hold = '0;
                host_hold = '0;
                prev_stb = 1'b0;
                strobe_cnt = 0;
                exp_strobes = 0;
                continue;
            end
            if (cpu_stall_o) stall_cycles++;
            if (pia_stb_o) begin
                check("stb_single_cycle", prev_stb, 0);
                last_we = pia_we_o;
                last_adr = pia_adr_o;
                last_dat = pia_dat_o;
                strobe_cnt++;
            end
            prev_stb = pia_stb_o;
            if (cpu_ack_o) begin
                check("ack_exclusive", host_ack_o, 0);
                check("stall_in_ack", cpu_stall_o, 0);
                if (cpu_q.size() == 0) begin
                    check("cpu_unexpected_ack", 1, 0);
                end else begin
                    t = cpu_q.pop_front();
                    score("cpu", t, cpu_dat_o, 1'b0, cpu_hold);
                end
            end else begin
                check("cpu_dat_hold", cpu_dat_o, cpu_hold);
            end
            if (host_ack_o) begin
                if (host_q.size() == 0) begin
                    check("host_unexpected_ack", 1, 0);
                end else begin
                    t = host_q.pop_front();
                    score("host", t, host_dat_o, host_err_o, host_hold);
                end
            end else begin
                check("host_dat_hold", host_dat_o, host_hold);
                check("host_err_idle", host_err_o, 0);
            end
        end
    end

    task automatic cpu_txn(input logic we, input logic [6:0] adr, input logic [7:0] dat,
                           input bit perturb, output int lat);
        txn_t t;
        t.we = we; t.adr = adr; t.dat = dat; t.err = 1'b0;
        cpu_q.push_back(t);
        cpu_we_i = we; cpu_adr_i = adr; cpu_dat_i = dat; cpu_stb_i = 1'b1;
        lat = 0;
        forever begin
            @(negedge clk);
            if (cpu_ack_o) break;
            lat++;
            if (lat > 60) begin
                check("cpu_ack_timeout", 1, 0);
                break;
            end
            if (perturb) begin
                @(posedge clk);
                #1;
                cpu_adr_i = 7'($urandom);
                cpu_dat_i = 8'($urandom);
                cpu_we_i  = ~we;
            end
        end
        @(posedge clk);
        #1;
        cpu_stb_i = 1'b0;
    endtask

    task automatic host_txn(input logic we, input logic [6:0] adr, input logic [7:0] dat,
                            output int lat);
        txn_t t;
        t.we = we; t.adr = adr; t.dat = dat;
        t.err = HOST_SAFE && !we && (adr == 7'h04 || adr == 7'h05);
        host_q.push_back(t);
        host_we_i = we; host_adr_i = adr; host_dat_i = dat; host_stb_i = 1'b1;
        lat = 0;
        forever begin
            @(negedge clk);
            if (host_ack_o) break;
            lat++;
            if (lat > 60) begin
                check("host_ack_timeout", 1, 0);
                break;
            end
        end
        @(posedge clk);
        #1;
        host_stb_i = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int lat, lc, lh;
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, lc, lh;
        repeat (3) @(posedge clk);
        #1;
        check("rst_pia_stb", pia_stb_o, 0);
        check("rst_pia_bus", {pia_we_o, pia_adr_o, pia_dat_o}, 0);
        check("rst_acks", {cpu_ack_o, host_ack_o, host_err_o}, 0);
        check("rst_dat_o", {cpu_dat_o, host_dat_o}, 0);
        rst_ni = 1'b1;
        idle(2);

        // Lone CPU read, then lone CPU write.
        stall_cycles = 0;
        cpu_txn(1'b0, 7'h02, 8'h00, 1'b0, lat);
        check("cpu_read_latency", lat, 2);
        check("cpu_read_rdata_fd", cpu_hold, 8'hFD);
        check("cpu_read_no_stall", stall_cycles, 0);
        cpu_txn(1'b1, 7'h10, 8'h3C, 1'b0, lat);
        check("cpu_write_latency", lat, 1);
        idle(2);

        // Simultaneous writes: CPU first, host in the next IDLE.
        stall_cycles = 0;
        fork
            cpu_txn(1'b1, 7'h16, 8'h40, 1'b0, lc);
            host_txn(1'b1, 7'h01, 8'hFF, lh);
        join
        check("simul_cpu_latency", lc, 1);
        check("simul_host_latency", lh, 3);
        check("simul_cpu_no_stall", stall_cycles, 0);
        idle(2);

        // Side-effecting host reads are answered locally; others are forwarded.
        host_txn(1'b0, 7'h05, 8'h00, lat);
        check("host_safe_instat_latency", lat, 1);
        host_txn(1'b0, 7'h04, 8'h00, lat);
        check("host_safe_intim_latency", lat, 1);
        host_txn(1'b0, 7'h06, 8'h00, lat);
        check("host_plain_read_latency", lat, 2);
        host_txn(1'b1, 7'h15, 8'h22, lat);
        check("host_timer_write_latency", lat, 1);
        idle(2);

        // Requester inputs change after grant; the latched access must win.
        cpu_txn(1'b0, 7'h0A, 8'h00, 1'b1, lat);
        check("hold_latency", lat, 2);
        idle(2);

        // Starvation: CPU reads back to back while a host read waits.
        stall_cycles = 0;
        fork
            host_txn(1'b0, 7'h00, 8'h00, lh);
            for (int i = 0; i < 7; i++) cpu_txn(1'b0, 7'($urandom), 8'h00, 1'b0, lc);
        join
        check("starve_host_latency", lh, 17);
        check("starve_stall_cycles", stall_cycles, 3);
        idle(2);

        // Reset during the ACCESS cycle of a CPU read.
        cpu_we_i = 1'b0; cpu_adr_i = 7'h03; cpu_stb_i = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        check("abort_in_access", pia_stb_o, 1);
        #1;
        rst_ni = 1'b0;
        #1;
        check("abort_stb_low", pia_stb_o, 0);
        check("abort_no_ack", {cpu_ack_o, host_ack_o}, 0);
        @(posedge clk);
        #1;
        check("abort_held_idle", pia_stb_o, 0);
        rst_ni = 1'b1;
        cpu_txn(1'b0, 7'h03, 8'h00, 1'b0, lat);
        check("abort_retry_latency", lat, 2);
        idle(2);

        // Random concurrent traffic against latency bounds and the scoreboard.
        fork
            for (int i = 0; i < 80; i++) begin
                repeat ($urandom_range(0, 3)) @(posedge clk);
                #1;
                cpu_txn(1'($urandom), 7'($urandom), 8'($urandom), 1'b0, lc);
                check("cpu_latency_bound", lc <= 5, 1);
            end
            for (int i = 0; i < 40; i++) begin
                logic [6:0] a;
                repeat ($urandom_range(0, 5)) @(posedge clk);
                #1;
                a = ($urandom_range(0, 3) == 0) ? 7'(4 + $urandom_range(0, 1)) : 7'($urandom);
                host_txn(1'($urandom), a, 8'($urandom), lh);
                check("host_latency_bound", lh <= 19, 1);
            end
        join
        idle(4);
        check("cpu_queue_drained", cpu_q.size(), 0);
        check("host_queue_drained", host_q.size(), 0);
        check("strobe_count", strobe_cnt, exp_strobes);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pia_bus_arbiter.md
Name: pia_bus_arbiter

Overview:
Shares the single PIA (RIOT) register bus between two requesters: the 6502 CPU and a host debug port (ESP32/OSD peek-poke). Sits between the CPU address decoder, the host bridge and the PIA.
- Drives the PIA strobe/address/data interface.
- Returns read data and acks to the winning requester.
- Gives the CPU fixed priority, bounded by a host anti-starvation counter.
- Optionally blocks host reads of side-effecting registers.

Parameters:
MAX_WAIT, 15, host-pending cycles (4-bit counter) after which the host wins the next grant.
HOST_SAFE, 1, when 1, host reads of 7'h04 (INTIM) and 7'h05 (INSTAT) are not forwarded to the PIA.

Ports:
clk_i  in  1  system clock.
rst_ni  in  1  reset, asynchronous, active-low.
cpu_stb_i  in  1  CPU request, held until cpu_ack_o.
cpu_we_i  in  1  CPU write.
cpu_adr_i  in  7  CPU register address.
cpu_dat_i  in  8  CPU write data.
cpu_ack_o  out  1  one-cycle completion pulse to the CPU.
cpu_dat_o  out  8  CPU read data, valid with cpu_ack_o.
cpu_stall_o  out  1  high while cpu_stb_i is pending and not granted.
host_stb_i  in  1  host request, held until host_ack_o.
host_we_i  in  1  host write.
host_adr_i  in  7  host register address.
host_dat_i  in  8  host write data.
host_ack_o  out  1  one-cycle completion pulse to the host.
host_dat_o  out  8  host read data, valid with host_ack_o.
host_err_o  out  1  pulses with host_ack_o when a read was blocked.
pia_stb_o  out  1  PIA strobe.
pia_we_o  out  1  PIA write enable.
pia_adr_o  out  7  PIA address.
pia_dat_o  out  8  PIA write data.
pia_dat_i  in  8  PIA read data, registered one cycle after the strobe.

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE.
  - All outputs 0. wait_cnt = 0. Data capture regs = 0.
- States:
  - IDLE: evaluate grant.
  - ACCESS: pia_stb_o = 1 for exactly one cycle, using the latched requester's we/adr/dat.
  - CAPTURE: reads only; sample pia_dat_i.
- Grant rule (IDLE, both pending):
  - Host wins if wait_cnt == MAX_WAIT; otherwise CPU wins.
  - With a single requester, that requester wins.
  - The grant owner, we, adr and dat are registered at grant. Requester inputs are ignored until its ack.
- Write timing:
  - ACCESS cycle asserts ack to the owner.
  - Then return to IDLE.
  - Total: grant cycle + 1. Ack arrives 2 cycles after stb seen in IDLE.
- Read timing:
  - ACCESS, then CAPTURE.
  - In CAPTURE: owner dat_o <= pia_dat_i, ack pulses, return to IDLE.
  - Ack arrives 3 cycles after stb seen in IDLE.
- Back-to-back: a new grant may be taken in the IDLE cycle directly after ack; there is no dead cycle beyond IDLE.
- wait_cnt:
  - Increments, saturating at MAX_WAIT, each cycle host_stb_i is high and the host is not the owner.
  - Clears to 0 when the host is granted, or when host_stb_i is low.
- cpu_stall_o = cpu_stb_i && !(owner==CPU && state!=IDLE). It is combinational from state and is 0 in the ack cycle.
- HOST_SAFE=1 and host read with adr 7'h04 or 7'h05:
  - No PIA strobe.
  - Next cycle: host_ack_o=1, host_dat_o=8'h00, host_err_o=1.
  - CPU ownership is not consumed.
- Host writes are always forwarded; this includes timer writes 7'h14–7'h17.
- Out-of-range addresses are forwarded unchanged; decode belongs to the PIA.
- cpu_dat_o / host_dat_o hold their last captured value between acks.
- A requester dropping stb before ack is a protocol violation. The latched transaction still completes and acks.
- Reset mid-access aborts immediately: pia_stb_o = 0 and no ack is issued.

Decomposition:
- Shared package pia_bus_pkg holds:
  - state enum {IDLE, ACCESS, CAPTURE, BLOCKED}.
  - owner enum {OWN_CPU, OWN_HOST}.
  - Address constants ADR_INTIM=7'h04, ADR_INSTAT=7'h05.
- One sub-module, pia_starve_cnt: the saturating wait counter with inc/clr/at_max.
- The FSM and muxing stay in the top level.

Test Plan:
- CPU read only:
  - Stimulus: cpu_stb_i=1, adr 7'h02; PIA returns 8'hFD.
  - Response: pia_stb_o high for 1 cycle; cpu_ack_o 3 cycles after stb; cpu_dat_o=8'hFD; cpu_stall_o=0 throughout.
- Simultaneous requests:
  - Stimulus: CPU write 7'h16/8'h40 and host write 7'h01/8'hFF at the same time.
  - Response: CPU granted first (pia_adr_o=7'h16); host granted in the next IDLE (pia_adr_o=7'h01); cpu_stall_o low; host acked 2 cycles after CPU ack.
- Starvation:
  - Stimulus: CPU issues continuous back-to-back reads; host read 7'h00 pending.
  - Response: once wait_cnt reaches 15 (MAX_WAIT), host wins the next IDLE; cpu_stall_o high for 3 cycles; wait_cnt returns to 0.
- HOST_SAFE:
  - Stimulus: host read 7'h05.
  - Response: no pia_stb_o; host_ack_o + host_err_o one cycle after grant; host_dat_o=8'h00.
  - Repeat with HOST_SAFE=0: forwarded; host_err_o=0.
- Reset abort:
  - Stimulus: drop rst_ni during the ACCESS of a CPU read.
  - Response: pia_stb_o and all acks go 0 asynchronously; after release, state IDLE; the retried stb completes normally.
- Hold behaviour:
  - Stimulus: change cpu_adr_i during CAPTURE.
  - Response: pia_adr_o is unaffected; ack returns data for the originally latched address.
